multi_cycle_riscv: RTL

Parametrised multi-cycle successor to the team's single-cycle mini RISC-V datapath.
- Executes the same RV32I subset (add, sub, and, or, slt, addi, lw, sw, beq, jal) over several states of an FSM.
- Uses one unified memory port with a req/ack handshake, so instruction and data memory may be shared and have variable latency.
- Sits between the lab top level and a single memory/bus model.

---
 rtl/riscv_pkg.sv | 44 ++++
 rtl/core_regfile.sv | 42 ++++
 rtl/multi_cycle_riscv.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/riscv_pkg.sv
// Shared constants for the multi-cycle mini RV32I core:
// opcodes, ALU control codes, FSM state codes and the ALU decoder.
package riscv_pkg;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    typedef logic [2:0] alu_ctl_t;
    localparam alu_ctl_t ALU_ADD = 3'd0;
    localparam alu_ctl_t ALU_SUB = 3'd1;
    localparam alu_ctl_t ALU_AND = 3'd2;
    localparam alu_ctl_t ALU_OR  = 3'd3;
    localparam alu_ctl_t ALU_SLT = 3'd4;

    typedef logic [2:0] state_t;
    localparam state_t BOOT   = 3'd0;
    localparam state_t FETCH  = 3'd1;
    localparam state_t DECODE = 3'd2;
    localparam state_t EXEC   = 3'd3;
    localparam state_t MEM    = 3'd4;
    localparam state_t WB     = 3'd5;
    localparam state_t HALT   = 3'd6;

    // Only R-type selects via funct3/funct7; everything else adds.
    function automatic alu_ctl_t alu_decode(
        input logic       is_r,
        input logic [2:0] f3,
        input logic       f7b5
    );
        if (!is_r) return ALU_ADD;
        case (f3)
            3'b000:  return f7b5 ? ALU_SUB : ALU_ADD;
            3'b010:  return ALU_SLT;
            3'b110:  return ALU_OR;
            3'b111:  return ALU_AND;
            default: return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/core_regfile.sv
// Register file: two combinational read ports, one synchronous write port.
// x0 and (for NREGS=16) indices >= 16 read as zero and drop writes.
module core_regfile #(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    localparam int IW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];

    logic wr_ok;
    logic rd1_ok;
    logic rd2_ok;

    assign wr_ok  = (waddr != 5'd0) && (NREGS == 32 || !waddr[4]);
    assign rd1_ok = (raddr1 != 5'd0) && (NREGS == 32 || !raddr1[4]);
    assign rd2_ok = (raddr2 != 5'd0) && (NREGS == 32 || !raddr2[4]);

    assign rdata1 = rd1_ok ? regs[raddr1[IW-1:0]] : '0;
    assign rdata2 = rd2_ok ? regs[raddr2[IW-1:0]] : '0;

    // Clear on reset, otherwise a single guarded write per cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else if (we && wr_ok) begin
            regs[waddr[IW-1:0]] <= wdata;
        end
    end

endmodule

// File: rtl/multi_cycle_riscv.sv
// Multi-cycle RV32I subset core on one shared req/ack memory port.
// Optional macro ILLEGAL_HALT_EN: unknown opcodes stop the core in HALT.
module multi_cycle_riscv
    import riscv_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              NREGS    = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clock,
    input  logic            reset,
    output logic            mem_req,
    output logic            mem_we,
    output logic [XLEN-1:0] mem_addr,
    output logic [XLEN-1:0] mem_wdata,
    input  logic [XLEN-1:0] mem_rdata,
    input  logic            mem_ack,
    output logic            retire,
    output logic [XLEN-1:0] pc_out,
    output logic            halted
);

    state_t          state;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] ipc;
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] a_q;
    logic [XLEN-1:0] b_q;
    logic [XLEN-1:0] alu_q;
    logic [XLEN-1:0] mdr;

    logic [6:0] opcode;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;

    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];

    logic is_r, is_i, is_lw, is_sw, is_beq, is_jal, is_known;

    assign is_r     = opcode == OP_R;
    assign is_i     = opcode == OP_I;
    assign is_lw    = opcode == OP_LW;
    assign is_sw    = opcode == OP_SW;
    assign is_beq   = opcode == OP_BEQ;
    assign is_jal   = opcode == OP_JAL;
    assign is_known = is_r | is_i | is_lw | is_sw | is_beq | is_jal;

    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            rf_we;
    logic [XLEN-1:0] rf_wdata;

    assign rf_we    = state == WB;
    assign rf_wdata = is_lw ? mdr : alu_q;

    core_regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_rf (
        .clock  (clock),
        .reset  (reset),
        .we     (rf_we),
        .waddr  (rd),
        .wdata  (rf_wdata),
        .raddr1 (rs1),
        .raddr2 (rs2),
        .rdata1 (rd1),
        .rdata2 (rd2)
    );

    // Immediate generator: I by default, S/B/J by opcode.
    logic [XLEN-1:0] imm;
    always_comb begin
        imm = {{20{instr[31]}}, instr[31:20]};
        unique case (1'b1)
            is_sw:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            is_beq:  imm = {{19{instr[31]}}, instr[31], instr[7],
                            instr[30:25], instr[11:8], 1'b0};
            is_jal:  imm = {{11{instr[31]}}, instr[31], instr[19:12],
                            instr[20], instr[30:21], 1'b0};
            default: ;
        endcase
    end

    alu_ctl_t        alu_ctl;
    logic [XLEN-1:0] opb;
    logic [XLEN-1:0] alu_res;

    assign alu_ctl = alu_decode(is_r, instr[14:12], instr[30]);
    assign opb     = is_r ? b_q : imm;

    // ALU: addresses for lw/sw fall out of the ADD default.
    always_comb begin
        alu_res = a_q + opb;
        case (alu_ctl)
            ALU_SUB: alu_res = a_q - opb;
            ALU_AND: alu_res = a_q & opb;
            ALU_OR:  alu_res = a_q | opb;
            ALU_SLT: alu_res = {{(XLEN-1){1'b0}},
                                $signed(a_q) < $signed(opb)};
            default: ;
        endcase
    end

    logic [XLEN-1:0] pc_next4;
    assign pc_next4 = pc + 32'd4;

    // Main FSM and datapath registers; reset aborts any pending access.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= BOOT;
            pc    <= RESET_PC;
            ipc   <= RESET_PC;
            instr <= '0;
            a_q   <= '0;
            b_q   <= '0;
            alu_q <= '0;
            mdr   <= '0;
        end else begin
            case (state)
                BOOT: state <= FETCH;
                FETCH: begin
                    ipc <= pc;
                    if (mem_ack) begin
                        instr <= mem_rdata;
                        state <= DECODE;
                    end
                end
                DECODE: begin
                    a_q <= rd1;
                    b_q <= rd2;
                    if (is_known) begin
                        state <= EXEC;
                    end else begin
`ifdef ILLEGAL_HALT_EN
                        state <= HALT;
`else
                        pc    <= pc_next4;
                        state <= FETCH;
`endif
                    end
                end
                EXEC: begin
                    alu_q <= is_jal ? pc_next4 : alu_res;
                    if (is_beq) begin
                        pc    <= (a_q == b_q) ? pc + imm : pc_next4;
                        state <= FETCH;
                    end else if (is_jal) begin
                        pc    <= pc + imm;
                        state <= WB;
                    end else if (is_lw || is_sw) begin
                        state <= MEM;
                    end else begin
                        state <= WB;
                    end
                end
                MEM: begin
                    if (mem_ack) begin
                        if (is_sw) begin
                            pc    <= pc_next4;
                            state <= FETCH;
                        end else begin
                            mdr   <= mem_rdata;
                            state <= WB;
                        end
                    end
                end
                WB: begin
                    if (!is_jal) pc <= pc_next4;
                    state <= FETCH;
                end
                HALT: state <= HALT;
                default: state <= BOOT;
            endcase
        end
    end

    assign mem_req   = (state == FETCH) || (state == MEM);
    assign mem_we    = (state == MEM) && is_sw;
    assign mem_addr  = (state == MEM) ? alu_q : pc;
    assign mem_wdata = b_q;

    // ipc tracks the in-flight instruction once jal has moved pc.
    assign pc_out = (state == BOOT || state == FETCH || state == HALT)
                  ? pc : ipc;

`ifdef ILLEGAL_HALT_EN
    assign halted = state == HALT;
    assign retire = (state == WB)
                  | ((state == EXEC) & is_beq)
                  | ((state == MEM) & is_sw & mem_ack);
`else
    assign halted = 1'b0;
    assign retire = (state == WB)
                  | ((state == EXEC) & is_beq)
                  | ((state == MEM) & is_sw & mem_ack)
                  | ((state == DECODE) & ~is_known);
`endif

endmodule
